// File: rtl/mq_pkg.sv
// Shared constants and FSM state type for the MQ CX/D scheduler.
package mq_pkg;

    localparam int CX_W  = 5;
    localparam int N_REQ = 4;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        GRANT     = 2'd1,
        FLUSH     = 2'd2,
        WAIT_DONE = 2'd3
    } state_t;

endpackage

// File: rtl/mq_rr_arbiter.sv
// Rotating-priority selector: first asserted request strictly after ptr,
// wrapping, so the lane at ptr itself has lowest priority.
module mq_rr_arbiter
    import mq_pkg::*;
#(
    parameter int N_REQ = mq_pkg::N_REQ,
    parameter int ID_W  = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  ptr,
    output logic [N_REQ-1:0] gnt,
    output logic [ID_W-1:0]  gnt_id,
    output logic             gnt_any
);

    // Scan from the farthest lane back to ptr+1 so the nearest requester wins.
    always_comb begin
        int idx;
        gnt     = '0;
        gnt_id  = '0;
        gnt_any = 1'b0;
        idx     = 0;
        for (int k = N_REQ; k >= 1; k--) begin
            idx = (int'(ptr) + k) % N_REQ;
            if (req[idx]) begin
                gnt      = '0;
                gnt[idx] = 1'b1;
                gnt_id   = ID_W'(idx);
                gnt_any  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mq_cxd_scheduler.sv
// Round-robin scheduler sharing one MQ coder between N_REQ bit-plane lanes.
// The grant is locked for a whole segment; termination forwards the last
// symbol, pulses flush_out alongside it, then waits for flush_done.
// Optional: define MQ_SCHED_TIMEOUT_EN to force a flush after IDLE_TIMEOUT
// owner-silent cycles in GRANT (sets sticky timeout_err).
module mq_cxd_scheduler
    import mq_pkg::*;
#(
    parameter int N_REQ        = mq_pkg::N_REQ,
    parameter int CX_W         = mq_pkg::CX_W,
    parameter int ID_W         = $clog2(N_REQ),
    parameter int IDLE_TIMEOUT = 256
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_REQ-1:0]      req_valid,
    input  logic [N_REQ*CX_W-1:0] req_cx,
    input  logic [N_REQ-1:0]      req_d,
    input  logic [N_REQ-1:0]      req_last,
    output logic [N_REQ-1:0]      req_ready,
    input  logic                  coder_ready,
    output logic [CX_W-1:0]       cx_out,
    output logic                  d_out,
    output logic                  sym_valid,
    output logic                  flush_out,
    input  logic                  flush_done,
    output logic [ID_W-1:0]       grant_id,
    output logic                  busy,
    output logic                  timeout_err
);

    if (N_REQ < 2 || N_REQ > 8 || IDLE_TIMEOUT < 2) begin : g_bad_cfg
        $error("mq_cxd_scheduler: N_REQ must be 2..8 and IDLE_TIMEOUT >= 2");
    end

    state_t           state;
    logic [ID_W-1:0]  ptr;
    logic [N_REQ-1:0] owner_oh;
    logic [N_REQ-1:0] arb_oh;
    logic [ID_W-1:0]  arb_idx;
    logic             arb_any;
    logic             xfer;
    logic             to_hit;

    mq_rr_arbiter #(.N_REQ(N_REQ), .ID_W(ID_W)) u_arb (
        .req     (req_valid),
        .ptr     (ptr),
        .gnt     (arb_oh),
        .gnt_id  (arb_idx),
        .gnt_any (arb_any)
    );

    // Only the locked owner sees ready, and only while the coder can accept.
    assign req_ready = (state == GRANT && coder_ready) ? owner_oh : '0;
    assign xfer      = |(req_valid & req_ready);
    assign busy      = (state != IDLE);

`ifdef MQ_SCHED_TIMEOUT_EN
    localparam int TO_W = $clog2(IDLE_TIMEOUT + 1);
    logic [TO_W-1:0] idle_cnt;

    assign to_hit = (state == GRANT) && !xfer && (idle_cnt == TO_W'(IDLE_TIMEOUT - 1));

    // Count owner-silent GRANT cycles; latch the forced-flush flag until reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idle_cnt    <= '0;
            timeout_err <= 1'b0;
        end else begin
            if (state != GRANT || xfer) idle_cnt <= '0;
            else                        idle_cnt <= idle_cnt + 1'b1;
            if (to_hit) timeout_err <= 1'b1;
        end
    end
`else
    assign to_hit      = 1'b0;
    assign timeout_err = 1'b0;
`endif

    // FSM, RR pointer and the registered symbol/flush stage toward the coder.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            ptr       <= ID_W'(N_REQ - 1);
            grant_id  <= '0;
            owner_oh  <= '0;
            cx_out    <= '0;
            d_out     <= 1'b0;
            sym_valid <= 1'b0;
            flush_out <= 1'b0;
        end else begin
            sym_valid <= xfer;
            flush_out <= 1'b0;
            if (xfer) begin
                cx_out <= req_cx[grant_id*CX_W +: CX_W];
                d_out  <= req_d[grant_id];
            end
            case (state)
                IDLE: if (arb_any) begin
                    grant_id <= arb_idx;
                    owner_oh <= arb_oh;
                    state    <= GRANT;
                end
                // flush_out registers with the last symbol so it never leads data.
                GRANT: if ((xfer && req_last[grant_id]) || to_hit) begin
                    flush_out <= 1'b1;
                    state     <= FLUSH;
                end
                FLUSH: state <= WAIT_DONE;
                WAIT_DONE: if (flush_done) begin
                    ptr   <= grant_id;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mq_cxd_scheduler.sv
// Self-checking bench for mq_cxd_scheduler: per-lane symbol queues feed the
// DUT; a segment-level reference model predicts grants, symbol stream,
// flush timing, busy and req_ready.
module tb_mq_cxd_scheduler;

    localparam int N   = 4;
    localparam int CXW = 5;
    localparam int IDW = 2;
    localparam int TO  = 8;

    typedef struct {
        logic [CXW-1:0] cx;
        logic           d;
        logic           last;
    } sym_t;

    logic             clk = 1'b0;
    logic             rst;
    logic [N-1:0]     req_valid, req_d, req_last, req_ready;
    logic [N*CXW-1:0] req_cx;
    logic             coder_ready, flush_done;
    logic [CXW-1:0]   cx_out;
    logic             d_out, sym_valid, flush_out, busy, timeout_err;
    logic [IDW-1:0]   grant_id;

    always #5 clk = ~clk;

    mq_cxd_scheduler #(.N_REQ(N), .CX_W(CXW), .ID_W(IDW), .IDLE_TIMEOUT(TO)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_cx      (req_cx),
        .req_d       (req_d),
        .req_last    (req_last),
        .req_ready   (req_ready),
        .coder_ready (coder_ready),
        .cx_out      (cx_out),
        .d_out       (d_out),
        .sym_valid   (sym_valid),
        .flush_out   (flush_out),
        .flush_done  (flush_done),
        .grant_id    (grant_id),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: lane queues plus segment-level ownership.
    // phase: 0 no owner, 1 owner streaming, 2 flush cycle, 3 awaiting done.
    sym_t           lane_q[N][$];
    int             phase, owner, last_owner, idle_cnt, done_dly, exp_gid;
    logic [CXW-1:0] exp_cx;
    logic           exp_d, exp_terr;
    int             order_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        phase = 0; owner = 0; last_owner = N - 1; idle_cnt = 0; done_dly = 0;
        exp_gid = 0; exp_cx = '0; exp_d = 1'b0; exp_terr = 1'b0;
    endtask

    function automatic int rr_next();
        for (int k = 1; k <= N; k++)
            if (lane_q[(last_owner + k) % N].size() > 0) return (last_owner + k) % N;
        return -1;
    endfunction

    function automatic bit all_empty();
        for (int i = 0; i < N; i++) if (lane_q[i].size() > 0) return 1'b0;
        return 1'b1;
    endfunction

    task automatic push_seg(input int lane, input int len);
        sym_t s;
        for (int j = 0; j < len; j++) begin
            s.cx = CXW'($urandom); s.d = 1'($urandom); s.last = (j == len - 1);
            lane_q[lane].push_back(s);
        end
    endtask

    task automatic drive_lanes();
        for (int i = 0; i < N; i++) begin
            req_valid[i] = lane_q[i].size() > 0;
            req_cx[i*CXW +: CXW] = req_valid[i] ? lane_q[i][0].cx : '0;
            req_d[i]    = req_valid[i] ? lane_q[i][0].d    : 1'b0;
            req_last[i] = req_valid[i] ? lane_q[i][0].last : 1'b0;
        end
    endtask

    // Runs cycles from just after a negedge; stops when all work is done,
    // after stop_at cycles (if nonzero), or when the cycle budget expires.
    task automatic run(input int max_cyc, input int rmode, input int lo_start, input int stop_at);
        int         cyc;
        logic       xfer, sv;
        sym_t       s;
        logic [N-1:0] exp_rdy;
        cyc = 0;
        while (1) begin
            if (stop_at == 0 && phase == 0 && all_empty()) break;
            if (stop_at != 0 && cyc == stop_at) break;
            if (cyc >= max_cyc) begin
                checks++; errors++;
                $error("FAIL cycle_budget: observed %0d cycles without completion, required < %0d", cyc, max_cyc);
                break;
            end
            drive_lanes();
            coder_ready = !(cyc >= lo_start && cyc < lo_start + 5) &&
                          (rmode == 0 || $urandom_range(3) != 0);
            flush_done  = (phase == 3 && done_dly == 0) ||
                          (rmode != 0 && phase != 3 && $urandom_range(7) == 0);
            #1;
            exp_rdy = (phase == 1 && coder_ready) ? N'(1 << owner) : '0;
            chk("req_ready", req_ready, exp_rdy);
            xfer = (phase == 1) && coder_ready && lane_q[owner].size() > 0;
            sv   = 1'b0;
            @(posedge clk);
            case (phase)
                0: begin
                    owner = rr_next();
                    if (owner >= 0) begin
                        exp_gid = owner; phase = 1; idle_cnt = 0; order_q.push_back(owner);
                    end else owner = exp_gid;
                end
                1: begin
                    if (xfer) begin
                        s = lane_q[owner].pop_front();
                        sv = 1'b1; exp_cx = s.cx; exp_d = s.d; idle_cnt = 0;
                        if (s.last) phase = 2;
                    end else begin
                        idle_cnt++;
`ifdef MQ_SCHED_TIMEOUT_EN
                        if (idle_cnt == TO) begin phase = 2; exp_terr = 1'b1; end
`endif
                    end
                end
                2: begin
                    phase = 3;
                    done_dly = (rmode != 0) ? $urandom_range(3) : 1;
                end
                default: begin
                    if (flush_done) begin phase = 0; last_owner = owner; end
                    else done_dly--;
                end
            endcase
            @(negedge clk);
            chk("sym_valid", sym_valid, sv);
            chk("cx_out", cx_out, exp_cx);
            chk("d_out", d_out, exp_d);
            chk("flush_out", flush_out, phase == 2);
            chk("busy", busy, phase != 0);
            chk("grant_id", grant_id, exp_gid);
            chk("timeout_err", timeout_err, exp_terr);
            cyc++;
        end
    endtask

    initial begin
        int   exp_order[5];
        sym_t s;
        exp_order = '{0, 1, 2, 3, 0};
        rst = 1'b0; req_valid = '0; req_cx = '0; req_d = '0; req_last = '0;
        coder_ready = 1'b0; flush_done = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);

        // Reset state
        chk("rst_busy", busy, 0);
        chk("rst_sym_valid", sym_valid, 0);
        chk("rst_flush_out", flush_out, 0);
        chk("rst_grant_id", grant_id, 0);
        chk("rst_cx_out", cx_out, 0);
        chk("rst_d_out", d_out, 0);
        chk("rst_timeout_err", timeout_err, 0);
        rst = 1'b1;

        // Lane 0: three-symbol segment with fixed values
        s = '{cx: 5'h11, d: 1'b1, last: 1'b0}; lane_q[0].push_back(s);
        s = '{cx: 5'h02, d: 1'b0, last: 1'b0}; lane_q[0].push_back(s);
        s = '{cx: 5'h1F, d: 1'b1, last: 1'b1}; lane_q[0].push_back(s);
        run(200, 0, -100, 0);
        chk("t1_cx_last", cx_out, 5'h1F);

        // Move pointer to lane 3, then all four lanes with 1-symbol segments
        push_seg(3, 1);
        run(200, 0, -100, 0);
        order_q.delete();
        push_seg(0, 1); push_seg(0, 1);
        push_seg(1, 1); push_seg(2, 1); push_seg(3, 1);
        run(400, 0, -100, 0);
        chk("order_len", order_q.size(), 5);
        for (int k = 0; k < 5 && k < order_q.size(); k++) chk("grant_order", order_q[k], exp_order[k]);

        // coder_ready low for 5 cycles mid-segment
        push_seg(1, 6);
        run(200, 0, 2, 0);

        // flush_done pulsed in IDLE is ignored
        drive_lanes(); flush_done = 1'b1;
        @(negedge clk);
        flush_done = 1'b0;
        chk("idle_done_busy", busy, 0);
        chk("idle_done_gid", grant_id, 1);
        chk("idle_done_flush", flush_out, 0);

        // After owner 1 finishes, next grant goes to lane 2 ahead of lane 0
        order_q.delete();
        push_seg(0, 2); push_seg(1, 2); push_seg(2, 2);
        run(400, 0, -100, 0);
        chk("rr_after_1", order_q[0], 2);

        // Randomized traffic with coder stalls and spurious flush_done
        for (int k = 0; k < 40; k++) push_seg($urandom_range(N - 1), $urandom_range(1, 4));
        run(6000, 1, 30, 0);

        // Async reset during GRANT with owner still valid
        order_q.delete();
        push_seg(2, 8);
        run(100, 0, -100, 3);
        #2 rst = 1'b0;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_sym_valid", sym_valid, 0);
        chk("arst_flush_out", flush_out, 0);
        chk("arst_grant_id", grant_id, 0);
        chk("arst_cx_out", cx_out, 0);
        model_reset();
        order_q.delete();
        @(negedge clk);
        rst = 1'b1;
        push_seg(0, 2);
        run(400, 0, -100, 0);
        chk("arst_first_grant", order_q[0], 0);
        chk("arst_second_grant", order_q[1], 2);

`ifdef MQ_SCHED_TIMEOUT_EN
        // Owner goes silent after one non-last symbol
        s = '{cx: 5'h0A, d: 1'b1, last: 1'b0}; lane_q[3].push_back(s);
        run(200, 0, -100, 0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("to_sticky", timeout_err, 1);
        end
        rst = 1'b0;
        #1 chk("to_cleared", timeout_err, 0);
        @(negedge clk) rst = 1'b1;
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mq_cxd_scheduler.md
Name: mq_cxd_scheduler

Overview:
Shares one MQ coder datapath between N_REQ bit-plane-coder lanes, each delivering CX/D symbol streams per code-block segment. Grants one lane at a time, round-robin, and locks the grant until that lane's segment is terminated. Sequences termination: forwards the last symbol, pulses flush, then waits for the coder's flush_done before re-arbitrating. Sits directly upstream of the MQ coder input register stage and drives its CX, D and flush inputs.

Parameters:
N_REQ, 4, number of requesting lanes (2..8)
CX_W, 5, context label width
ID_W, $clog2(N_REQ), grant index width
IDLE_TIMEOUT, 256, owner-idle cycles before forced flush (optional feature only)

Ports:
clk  in  1  single clock, rising edge
rst  in  1  asynchronous, active-low reset
req_valid  in  N_REQ  lane has a symbol
req_cx  in  N_REQ*CX_W  per-lane context; lane i occupies bits [i*CX_W +: CX_W]
req_d  in  N_REQ  per-lane decision bit
req_last  in  N_REQ  symbol is the last of its segment
req_ready  out  N_REQ  symbol accepted this cycle when valid&ready
coder_ready  in  1  coder can take a symbol this cycle
cx_out  out  CX_W  registered context to coder
d_out  out  1  registered decision to coder
sym_valid  out  1  cx_out/d_out valid this cycle
flush_out  out  1  one-cycle terminate pulse to coder
flush_done  in  1  one-cycle pulse from coder: termination bytes emitted
grant_id  out  ID_W  current owner lane
busy  out  1  high in any state other than IDLE
timeout_err  out  1  sticky forced-flush flag; tied 0 without the feature

Behaviour:
- Reset (rst low, async): state IDLE. cx_out, d_out, sym_valid, flush_out, grant_id, busy and timeout_err all clear to 0. RR pointer is N_REQ-1, so lane 0 has first priority. Any in-flight segment is abandoned; no flush is issued.
- States: IDLE, GRANT, FLUSH, WAIT_DONE.
- IDLE:
  - If any req_valid: pick the first valid lane searching upward from pointer+1, with wrap.
  - Register grant_id, go to GRANT. Arbitration costs one cycle; req_ready is 0 in IDLE.
- GRANT:
  - req_ready[grant_id] = coder_ready (combinational). All other req_ready bits are 0.
  - A transfer is valid&ready on the owner lane. The next cycle presents cx_out/d_out with sym_valid=1 (latency 1).
  - sym_valid=0 on cycles with no transfer; cx_out/d_out hold their last value.
  - A transfer with req_last=1 goes to FLUSH.
- FLUSH:
  - flush_out=1 for exactly one cycle. This is the cycle in which the last symbol's sym_valid is high, so flush is never ahead of data.
  - Go to WAIT_DONE.
- WAIT_DONE:
  - No symbols are accepted.
  - On flush_done: pointer becomes grant_id, go to IDLE.
  - flush_done in any other state is ignored.
- Requests from other lanes during GRANT, FLUSH or WAIT_DONE are held off, not lost; lanes keep valid asserted.
- Fairness: a lane that is continuously valid is granted within N_REQ segments.
- grant_id holds its value through IDLE until the next grant.
- busy = (state != IDLE).

Optional Feature:
MQ_SCHED_TIMEOUT_EN
- Defined:
  - In GRANT, a counter increments on every cycle without an owner transfer and clears on each transfer.
  - On reaching IDLE_TIMEOUT: go to FLUSH without a last symbol and set timeout_err.
  - timeout_err is sticky until reset.
- Undefined: no counter; GRANT waits indefinitely; timeout_err is constant 0.

Decomposition:
- Package mq_pkg holds:
  - CX_W = 5;
  - the state enum {IDLE, GRANT, FLUSH, WAIT_DONE};
  - the default N_REQ.
- One sub-module, mq_rr_arbiter: combinational rotate-priority select from req vector and pointer, producing a one-hot grant and its index.
- Pointer register and FSM live in the top.

Test Plan:
- Reset then lane 0 sends 3 symbols (cx=5'h11,d=1; 5'h02,0; 5'h1F,1 with last):
  - sym_valid pulses follow, each 1 cycle after its transfer, with matching values;
  - flush_out is high alongside the third symbol;
  - busy=1 until flush_done.
- Lanes 0..3 all valid, each sending 1-symbol segments:
  - grant order is 0,1,2,3,0;
  - no req_ready to a non-owner lane ever.
- coder_ready held low for 5 cycles mid-segment:
  - req_ready stays 0, no sym_valid, no symbol lost or duplicated;
  - the stream resumes in order.
- flush_done pulsed in IDLE and GRANT: ignored. In WAIT_DONE it returns to IDLE and the next grant is the lane after the previous owner.
- rst asserted low during GRANT with owner valid: outputs clear immediately (async). After release, lane 0 has priority and no flush_out is issued.
- With MQ_SCHED_TIMEOUT_EN and IDLE_TIMEOUT=8, owner goes silent after 1 symbol: flush_out fires 8 cycles later and timeout_err=1 stays high until reset.
